// File: rtl/pkt_mem_responder.sv
// Avalon-MM burst responder backed by an internal registered-output RAM.
// Write bursts store beats at wrapped word indices; read bursts stream back one beat per cycle.
module pkt_mem_responder #(
    parameter int unsigned DEPTH_LOG2 = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] avs_s0_address,
    input  logic        avs_s0_read,
    input  logic        avs_s0_write,
    input  logic [31:0] avs_s0_writedata,
    input  logic [15:0] avs_s0_burstcount,
    output logic [31:0] avs_s0_readdata,
    output logic        avs_s0_readdatavalid,
    output logic        avs_s0_waitrequest,
    output logic        protocol_err,
    output logic        oob,
    output logic [31:0] wr_beats,
    output logic [31:0] rd_beats
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {IDLE, WR_BURST, RD_ISSUE, RD_LAST} state_t;

    state_t                state, next_state;
    logic [31:0]           mem [DEPTH];
    logic [DEPTH_LOG2-1:0] cmd_idx, idx, wr_idx;
    logic [15:0]           cmd_count, remaining;
    logic                  cmd_oob, wr_en;

    assign cmd_idx   = DEPTH_LOG2'(avs_s0_address >> 2);
    assign cmd_oob   = (avs_s0_address >> (DEPTH_LOG2 + 2)) != '0;
    assign cmd_count = (avs_s0_burstcount == 16'd0) ? 16'd1 : avs_s0_burstcount;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state         = state;
        wr_en              = 1'b0;
        wr_idx             = idx;
        avs_s0_waitrequest = (state == RD_ISSUE) || (state == RD_LAST);
        case (state)
            IDLE: begin
                // A simultaneous read is dropped in favour of the write.
                if (avs_s0_write) begin
                    wr_en  = 1'b1;
                    wr_idx = cmd_idx;
                    if (cmd_count != 16'd1) next_state = WR_BURST;
                end else if (avs_s0_read) begin
                    next_state = RD_ISSUE;
                end
            end
            WR_BURST: begin
                if (avs_s0_write) begin
                    wr_en = 1'b1;
                    if (remaining == 16'd1) next_state = IDLE;
                end
            end
            RD_ISSUE: if (remaining == 16'd1) next_state = RD_LAST;
            RD_LAST:  next_state = IDLE;
            default:  next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_idx] <= avs_s0_writedata;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx                  <= '0;
            remaining            <= '0;
            avs_s0_readdata      <= '0;
            avs_s0_readdatavalid <= 1'b0;
            protocol_err         <= 1'b0;
            oob                  <= 1'b0;
            wr_beats             <= '0;
            rd_beats             <= '0;
        end else begin
            avs_s0_readdatavalid <= 1'b0;
            protocol_err         <= 1'b0;
            oob                  <= 1'b0;
            if (wr_en) wr_beats <= wr_beats + 32'd1;
            case (state)
                IDLE: begin
                    if (avs_s0_write || avs_s0_read) begin
                        oob          <= cmd_oob;
                        protocol_err <= avs_s0_write && avs_s0_read;
                        // Beat 0 of a write is stored now, so the write pointer starts one ahead.
                        idx          <= avs_s0_write ? cmd_idx + 1'b1 : cmd_idx;
                        remaining    <= avs_s0_write ? cmd_count - 16'd1 : cmd_count;
                    end
                end
                WR_BURST: begin
                    protocol_err <= avs_s0_read;
                    if (avs_s0_write) begin
                        idx       <= idx + 1'b1;
                        remaining <= remaining - 16'd1;
                    end
                end
                RD_ISSUE: begin
                    avs_s0_readdata      <= mem[idx];
                    avs_s0_readdatavalid <= 1'b1;
                    rd_beats             <= rd_beats + 32'd1;
                    idx                  <= idx + 1'b1;
                    remaining            <= remaining - 16'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pkt_mem_responder.sv
// Directed bench for pkt_mem_responder: scoreboarded read data/latency plus pulse and counter checks.
module tb_pkt_mem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] address;
    logic        read, write;
    logic [31:0] writedata;
    logic [15:0] burstcount;
    logic [31:0] readdata;
    logic        readdatavalid, waitrequest, protocol_err, oob;
    logic [31:0] wr_beats, rd_beats;

    pkt_mem_responder #(.DEPTH_LOG2(10)) dut (
        .clk                  (clk),
        .reset                (reset),
        .avs_s0_address       (address),
        .avs_s0_read          (read),
        .avs_s0_write         (write),
        .avs_s0_writedata     (writedata),
        .avs_s0_burstcount    (burstcount),
        .avs_s0_readdata      (readdata),
        .avs_s0_readdatavalid (readdatavalid),
        .avs_s0_waitrequest   (waitrequest),
        .protocol_err         (protocol_err),
        .oob                  (oob),
        .wr_beats             (wr_beats),
        .rd_beats             (rd_beats)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t        q[$];
    logic [31:0] model [1024];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int          perr_cnt = 0;
    int          oob_cnt = 0;
    int          exp_wr = 0;
    int          exp_rd = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (readdatavalid) begin
            if (q.size() == 0) begin
                check("unexpected_rdv", {31'b0, readdatavalid}, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("rd_data", readdata, e.data);
                check("rd_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
        if (protocol_err) perr_cnt++;
        if (oob) oob_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_accept();
        int k = 0;
        while (waitrequest && k < 50) begin
            tick();
            k++;
        end
        check("accept_wait", {31'b0, waitrequest}, 32'd0);
    endtask

    task automatic wr_burst(input logic [31:0] addr, input int n, input logic [31:0] d0, input int gap);
        int unsigned base = (addr >> 2) % 1024;
        for (int i = 0; i < n; i++) begin
            address    = addr;
            burstcount = 16'(n);
            write      = 1'b1;
            writedata  = d0 + 32'(i);
            wait_accept();
            tick();
            model[(base + i) % 1024] = d0 + 32'(i);
            exp_wr++;
            write = 1'b0;
            repeat (gap) tick();
        end
    endtask

    task automatic rd_burst(input logic [31:0] addr, input int bc);
        int          beats = (bc == 0) ? 1 : bc;
        int unsigned base = (addr >> 2) % 1024;
        int          k = 0;
        address    = addr;
        burstcount = 16'(bc);
        read       = 1'b1;
        wait_accept();
        for (int i = 0; i < beats; i++) q.push_back('{model[(base + i) % 1024], cyc + 2 + i});
        tick();
        read = 1'b0;
        exp_rd += beats;
        while ((q.size() != 0 || waitrequest) && k < beats + 20) begin
            tick();
            k++;
        end
        check("rd_drain", 32'(q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int p0, o0, wh;
        reset = 1'b1; address = '0; read = 1'b0; write = 1'b0; writedata = '0; burstcount = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rdv", {31'b0, readdatavalid}, 32'd0);
        check("rst_rdata", readdata, 32'd0);
        check("rst_wait", {31'b0, waitrequest}, 32'd0);
        check("rst_perr", {31'b0, protocol_err}, 32'd0);
        check("rst_oob", {31'b0, oob}, 32'd0);
        check("rst_wr_beats", wr_beats, 32'd0);
        check("rst_rd_beats", rd_beats, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Basic 4-beat write then read back
        wr_burst(32'h100, 4, 32'hA0, 0);
        rd_burst(32'h100, 4);
        check("wr_beats_4", wr_beats, 32'd4);
        check("rd_beats_4", rd_beats, 32'd4);
        repeat (3) tick();
        check("rdata_hold", readdata, 32'hA3);

        // Write with gaps between beats
        p0 = perr_cnt;
        wr_burst(32'h200, 3, 32'hB0, 2);
        rd_burst(32'h200, 3);
        check("gap_no_perr", 32'(perr_cnt - p0), 32'd0);

        // Index wrap and out-of-window start
        o0 = oob_cnt;
        wr_burst(32'hFFC, 2, 32'hC0, 0);
        rd_burst(32'h000, 1);
        rd_burst(32'hFFC, 2);
        check("wrap_no_oob", 32'(oob_cnt - o0), 32'd0);
        rd_burst(32'h1000, 1);
        repeat (2) tick();
        check("oob_once", 32'(oob_cnt - o0), 32'd1);

        // Burstcount zero behaves as one beat
        rd_burst(32'h100, 0);

        // Long read holds waitrequest; writes in that window are refused
        wr_burst(32'h300, 8, 32'hD0, 0);
        address = 32'h300; burstcount = 16'd8; read = 1'b1;
        wait_accept();
        for (int i = 0; i < 8; i++) q.push_back('{model[(192 + i) % 1024], cyc + 2 + i});
        tick();
        exp_rd += 8;
        read = 1'b0; write = 1'b1; writedata = 32'hDEAD_BEEF; burstcount = 16'd1;
        wh = 0;
        for (int i = 0; i < 14; i++) begin
            if (waitrequest) wh++;
            if (i == 5) write = 1'b0;
            tick();
        end
        check("wait_cycles_8", 32'(wh), 32'd9);
        check("wr_blocked", wr_beats, 32'(exp_wr));
        check("rd_beats_long", rd_beats, 32'(exp_rd));
        rd_burst(32'h300, 1);

        // Read and write together in IDLE
        p0 = perr_cnt;
        address = 32'h400; burstcount = 16'd1; writedata = 32'h55; write = 1'b1; read = 1'b1;
        wait_accept();
        tick();
        model[256] = 32'h55;
        exp_wr++;
        write = 1'b0; read = 1'b0;
        repeat (3) tick();
        check("rw_perr_once", 32'(perr_cnt - p0), 32'd1);
        check("rw_no_rdv", 32'(q.size()), 32'd0);
        rd_burst(32'h400, 1);
        check("wr_beats_total", wr_beats, 32'(exp_wr));

        // Reset in the middle of a read
        address = 32'h300; burstcount = 16'd6; read = 1'b1;
        wait_accept();
        for (int i = 0; i < 6; i++) q.push_back('{model[(192 + i) % 1024], cyc + 2 + i});
        tick();
        read = 1'b0;
        tick();
        tick();
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_rdv", {31'b0, readdatavalid}, 32'd0);
        check("mid_rst_rdata", readdata, 32'd0);
        check("mid_rst_wait", {31'b0, waitrequest}, 32'd0);
        check("mid_rst_rd_beats", rd_beats, 32'd0);
        check("mid_rst_wr_beats", wr_beats, 32'd0);
        check("mid_rst_popped", 32'(q.size()), 32'd4);
        q.delete();
        exp_wr = 0;
        exp_rd = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        rd_burst(32'h300, 6);
        check("post_rst_rd_beats", rd_beats, 32'd6);

        repeat (4) tick();
        check("final_queue", 32'(q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
